// File: rtl/unidad_detencion.sv
// Stall/flush controller for the 5-stage filter pipeline: load-use bubbles, memory freeze, branch flush.
// Optional macro STALL_COUNT_EN enables the stall-cycle counter on stall_count.
module unidad_detencion #(
    parameter int LOAD_BUBBLES = 1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       Ra_F_Reg,
    input  logic             RE_A_F_Reg,
    input  logic [3:0]       Rb_F_Reg,
    input  logic             RE_B_F_Reg,
    input  logic [3:0]       Robj_Reg_Exe,
    input  logic             mem_RE_Reg_Exe,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             en_PC,
    output logic             en_F_Reg,
    output logic             en_Reg_Exe,
    output logic             en_Exe_Mem,
    output logic             en_Mem_WB,
    output logic             bubble_Reg_Exe,
    output logic             flush_F_Reg,
    output logic             mem_error,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } state_t;

    localparam logic [2:0] BC_INIT = 3'(LOAD_BUBBLES - 1);
    localparam logic [7:0] TC_MAX  = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [2:0] bc_q, bc_d;
    logic [7:0] tc_q, tc_d;
    logic       ret_q, ret_d;
    logic       err_d;
    logic       hz;
    logic       freeze;

    assign hz = mem_RE_Reg_Exe &&
                ((RE_A_F_Reg && (Ra_F_Reg == Robj_Reg_Exe)) ||
                 (RE_B_F_Reg && (Rb_F_Reg == Robj_Reg_Exe)));
    assign freeze = mem_req && !mem_ready;

    always_comb begin
        en_PC          = 1'b1;
        en_F_Reg       = 1'b1;
        en_Reg_Exe     = 1'b1;
        en_Exe_Mem     = 1'b1;
        en_Mem_WB      = 1'b1;
        bubble_Reg_Exe = 1'b0;
        flush_F_Reg    = 1'b0;
        state_d        = state_q;
        bc_d           = bc_q;
        tc_d           = tc_q;
        ret_d          = ret_q;
        err_d          = 1'b0;

        if (rst) begin
            en_PC          = 1'b0;
            bubble_Reg_Exe = 1'b1;
            flush_F_Reg    = 1'b1;
            state_d        = RUN;
            bc_d           = 3'd0;
            tc_d           = 8'd0;
            ret_d          = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (freeze) begin
                        {en_PC, en_F_Reg, en_Reg_Exe, en_Exe_Mem, en_Mem_WB} = 5'b0;
                        tc_d    = 8'd1;
                        ret_d   = 1'b0;
                        state_d = MEM_WAIT;
                    end else if (branch_taken) begin
                        // hazard against a flushed instruction is irrelevant
                        flush_F_Reg    = 1'b1;
                        bubble_Reg_Exe = 1'b1;
                    end else if (hz) begin
                        en_PC          = 1'b0;
                        en_F_Reg       = 1'b0;
                        bubble_Reg_Exe = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            bc_d    = BC_INIT;
                            state_d = LOAD_STALL;
                        end
                    end
                end
                LOAD_STALL: begin
                    if (freeze) begin
                        {en_PC, en_F_Reg, en_Reg_Exe, en_Exe_Mem, en_Mem_WB} = 5'b0;
                        tc_d    = 8'd1;
                        ret_d   = 1'b1;
                        state_d = MEM_WAIT;
                    end else begin
                        en_PC          = 1'b0;
                        en_F_Reg       = 1'b0;
                        bubble_Reg_Exe = 1'b1;
                        if (bc_q <= 3'd1) begin
                            bc_d    = 3'd0;
                            state_d = RUN;
                        end else begin
                            bc_d = bc_q - 3'd1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_d = ret_q ? LOAD_STALL : RUN;
                        ret_d   = 1'b0;
                        tc_d    = 8'd0;
                    end else if (tc_q == TC_MAX) begin
                        // access abandoned; any pending load stall is dropped too
                        err_d   = 1'b1;
                        state_d = RUN;
                        ret_d   = 1'b0;
                        bc_d    = 3'd0;
                        tc_d    = 8'd0;
                    end else begin
                        {en_PC, en_F_Reg, en_Reg_Exe, en_Exe_Mem, en_Mem_WB} = 5'b0;
                        tc_d = tc_q + 8'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    bc_d    = 3'd0;
                    tc_d    = 8'd0;
                    ret_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            bc_q      <= 3'd0;
            tc_q      <= 8'd0;
            ret_q     <= 1'b0;
            mem_error <= 1'b0;
        end else begin
            state_q   <= state_d;
            bc_q      <= bc_d;
            tc_q      <= tc_d;
            ret_q     <= ret_d;
            mem_error <= err_d;
        end
    end

    assign state = state_q;

`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en_PC && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_unidad_detencion.sv
// Bench for unidad_detencion: directed scenarios plus randomized run against a cycle-level reference model.
// Two instances: LOAD_BUBBLES=3/MEM_TIMEOUT=16/CNT_W=4 and LOAD_BUBBLES=1/MEM_TIMEOUT=3/CNT_W=16.
module tb_unidad_detencion;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] ra, rb, robj;
    logic       rea, reb, mre, mreq, mrdy, br;

    logic        en_pc3, en_f3, en_re3, en_em3, en_mw3, bub3, fl3, err3;
    logic [1:0]  st3;
    logic [3:0]  sc3;
    logic        en_pc1, en_f1, en_re1, en_em1, en_mw1, bub1, fl1, err1;
    logic [1:0]  st1;
    logic [15:0] sc1;

    int checks = 0;
    int errors = 0;

    unidad_detencion #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(16), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .Ra_F_Reg(ra), .RE_A_F_Reg(rea), .Rb_F_Reg(rb), .RE_B_F_Reg(reb),
        .Robj_Reg_Exe(robj), .mem_RE_Reg_Exe(mre), .mem_req(mreq), .mem_ready(mrdy),
        .branch_taken(br), .en_PC(en_pc3), .en_F_Reg(en_f3), .en_Reg_Exe(en_re3),
        .en_Exe_Mem(en_em3), .en_Mem_WB(en_mw3), .bubble_Reg_Exe(bub3), .flush_F_Reg(fl3),
        .mem_error(err3), .state(st3), .stall_count(sc3));

    unidad_detencion #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(3), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .Ra_F_Reg(ra), .RE_A_F_Reg(rea), .Rb_F_Reg(rb), .RE_B_F_Reg(reb),
        .Robj_Reg_Exe(robj), .mem_RE_Reg_Exe(mre), .mem_req(mreq), .mem_ready(mrdy),
        .branch_taken(br), .en_PC(en_pc1), .en_F_Reg(en_f1), .en_Reg_Exe(en_re1),
        .en_Exe_Mem(en_em1), .en_Mem_WB(en_mw1), .bubble_Reg_Exe(bub1), .flush_F_Reg(fl1),
        .mem_error(err1), .state(st1), .stall_count(sc1));

`ifdef STALL_COUNT_EN
    localparam logic [15:0] CMASK = 16'hFFFF;
`else
    localparam logic [15:0] CMASK = 16'h0000;
`endif

    // Model state: pending memory access and its wait count, remaining load-stall cycles,
    // error pulse due next cycle, and stall cycles seen so far.
    typedef struct packed {
        bit pend;
        int waited;
        int left;
        bit err;
        int cnt;
    } ms_t;

    typedef struct packed {
        logic       en_pc;
        logic       en_f;
        logic       en_o;
        logic       bub;
        logic       fl;
        logic [1:0] st;
    } mo_t;

    ms_t ms3 = '0;
    ms_t ms1 = '0;

    function automatic logic hz_now();
        return mre && ((rea && (ra == robj)) || (reb && (rb == robj)));
    endfunction

    function automatic void model_step(input int lb, input int tmo, input int cmax, input ms_t s,
                                       input logic r, input logic hzv, input logic req,
                                       input logic rdy, input logic brt,
                                       output mo_t o, output ms_t n);
        n = s;
        n.err = 1'b0;
        o.en_pc = 1'b1; o.en_f = 1'b1; o.en_o = 1'b1; o.bub = 1'b0; o.fl = 1'b0;
        o.st = s.pend ? 2'd2 : ((s.left != 0) ? 2'd1 : 2'd0);
        if (r) begin
            o.en_pc = 1'b0; o.bub = 1'b1; o.fl = 1'b1;
            n = '0;
        end else if (s.pend) begin
            if (rdy) n.pend = 1'b0;
            else if (s.waited == tmo) begin
                n.pend = 1'b0; n.left = 0; n.err = 1'b1;
            end else begin
                o.en_pc = 1'b0; o.en_f = 1'b0; o.en_o = 1'b0;
                n.waited = s.waited + 1;
            end
        end else if (req && !rdy) begin
            o.en_pc = 1'b0; o.en_f = 1'b0; o.en_o = 1'b0;
            n.pend = 1'b1; n.waited = 1;
        end else if (s.left != 0) begin
            o.en_pc = 1'b0; o.en_f = 1'b0; o.bub = 1'b1;
            n.left = s.left - 1;
        end else if (brt) begin
            o.bub = 1'b1; o.fl = 1'b1;
        end else if (hzv) begin
            o.en_pc = 1'b0; o.en_f = 1'b0; o.bub = 1'b1;
            n.left = lb - 1;
        end
        if (!r && !o.en_pc && (s.cnt < cmax)) n.cnt = s.cnt + 1;
    endfunction

    always @(posedge clk) begin : model_upd
        mo_t o3, o1;
        ms_t n3, n1;
        model_step(3, 16, 15, ms3, rst, hz_now(), mreq, mrdy, br, o3, n3);
        model_step(1, 3, 65535, ms1, rst, hz_now(), mreq, mrdy, br, o1, n1);
        ms3 <= n3;
        ms1 <= n1;
    end

    task automatic idle();
        ra = 4'd0; rb = 4'd0; robj = 4'd0;
        rea = 1'b0; reb = 1'b0; mre = 1'b0; mreq = 1'b0; mrdy = 1'b0; br = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1; idle();
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; idle(); robj = 4'd2; ra = 4'd2; rea = 1'b1; mre = 1'b1; mreq = 1'b1;
        #2;
        checks++;
        if ({en_pc3, en_f3, en_re3, en_em3, en_mw3, bub3, fl3} !== 7'b0111111) begin
            errors++; $display("FAIL reset_ctl3 got %b want 0111111", {en_pc3, en_f3, en_re3, en_em3, en_mw3, bub3, fl3});
        end
        checks++;
        if ({en_pc1, en_f1, en_re1, en_em1, en_mw1, bub1, fl1} !== 7'b0111111) begin
            errors++; $display("FAIL reset_ctl1 got %b want 0111111", {en_pc1, en_f1, en_re1, en_em1, en_mw1, bub1, fl1});
        end
        @(negedge clk); #2;
        checks++;
        if ({st3, err3, sc3, st1, err1, sc1} !== 25'd0) begin
            errors++; $display("FAIL reset_regs got st3=%0d err3=%0b sc3=%0d st1=%0d err1=%0b sc1=%0d want 0",
                               st3, err3, sc3, st1, err1, sc1);
        end
        @(negedge clk); rst = 1'b0; idle(); #2;
        checks++;
        if ({en_pc3, en_f3, en_re3, bub3, fl3, en_pc1, bub1, fl1} !== 8'b11100100) begin
            errors++; $display("FAIL reset_release got %b want 11100100", {en_pc3, en_f3, en_re3, bub3, fl3, en_pc1, bub1, fl1});
        end
    endtask

    task automatic test_load_use_1();
        apply_reset();
        @(negedge clk); robj = 4'd3; mre = 1'b1; ra = 4'd3; rea = 1'b1; #2;
        checks++;
        if ({en_pc1, en_f1, en_re1, en_em1, en_mw1, bub1, st1} !== 8'b00111100) begin
            errors++; $display("FAIL lu1_stall got %b want 00111100", {en_pc1, en_f1, en_re1, en_em1, en_mw1, bub1, st1});
        end
        @(negedge clk); idle(); #2;
        checks++;
        if ({en_pc1, en_f1, en_re1, bub1, st1} !== 6'b111000) begin
            errors++; $display("FAIL lu1_after got %b want 111000", {en_pc1, en_f1, en_re1, bub1, st1});
        end
    endtask

    task automatic test_load_use_3();
        logic [1:0] st_exp [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
            if (i == 0) begin robj = 4'd5; mre = 1'b1; rb = 4'd5; reb = 1'b1; ra = 4'd1; rea = 1'b1; end
            #2;
            checks++;
            if ({en_pc3, en_f3, en_re3, bub3, st3} !== {(i == 3), (i == 3), 1'b1, (i < 3), st_exp[i]}) begin
                errors++; $display("FAIL lu3_cycle%0d got pc=%b f=%b re=%b bub=%b st=%0d want pc=%b bub=%b st=%0d",
                                   i, en_pc3, en_f3, en_re3, bub3, st3, (i == 3), (i < 3), st_exp[i]);
            end
        end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle();
            if (i < 5) begin mreq = 1'b1; mrdy = (i == 4); end
            #2;
            if (i < 5) begin
                checks++;
                if ({en_pc3, en_f3, en_re3, en_em3, en_mw3, st3} !== {{5{i == 4}}, ((i == 0) ? 2'd0 : 2'd2)}) begin
                    errors++; $display("FAIL memwait_cycle%0d got en=%b st=%0d want en=%b", i,
                                       {en_pc3, en_f3, en_re3, en_em3, en_mw3}, st3, {5{i == 4}});
                end
            end else begin
                checks++;
                if ({st3, 12'(sc3)} !== {2'd0, 12'(16'd4 & CMASK)}) begin
                    errors++; $display("FAIL memwait_end got st=%0d sc=%0d want st=0 sc=%0d", st3, sc3, 16'd4 & CMASK);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int n_err = 0;
        int at = -1;
        apply_reset();
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk); idle(); mreq = 1'b1; #2;
            if (err3) begin n_err++; at = i; end
            if (i == 16) begin
                checks++;
                if ({en_pc3, en_mw3, bub3, st3} !== 5'b11010) begin
                    errors++; $display("FAIL tmo_abort got pc=%b mw=%b bub=%b st=%0d want 1 1 0 2", en_pc3, en_mw3, bub3, st3);
                end
            end
            if (i == 17) begin
                checks++;
                if (st3 !== 2'd0) begin
                    errors++; $display("FAIL tmo_state got %0d want 0", st3);
                end
            end
        end
        checks++;
        if (n_err !== 1 || at !== 17) begin
            errors++; $display("FAIL tmo_pulse got count=%0d at=%0d want count=1 at=17", n_err, at);
        end
        @(negedge clk); idle();
    endtask

    task automatic test_branch_hz();
        apply_reset();
        @(negedge clk); robj = 4'd7; mre = 1'b1; ra = 4'd7; rea = 1'b1; br = 1'b1; #2;
        checks++;
        if ({fl3, bub3, en_pc3, en_f3, fl1, bub1, en_pc1, en_f1} !== 8'hFF) begin
            errors++; $display("FAIL br_hz got %b want 11111111", {fl3, bub3, en_pc3, en_f3, fl1, bub1, en_pc1, en_f1});
        end
        @(negedge clk); idle(); #2;
        checks++;
        if ({en_pc3, bub3, st3, en_pc1, bub1, st1} !== 8'b10001000) begin
            errors++; $display("FAIL br_after got %b want 10001000", {en_pc3, bub3, st3, en_pc1, bub1, st1});
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        @(negedge clk); robj = 4'd9; mre = 1'b1; rb = 4'd9; reb = 1'b1; #2;
        @(negedge clk); idle(); rst = 1'b1; #2;
        checks++;
        if (st3 !== 2'd1) begin
            errors++; $display("FAIL rst_mid_pre got st=%0d want 1", st3);
        end
        @(negedge clk); rst = 1'b0; #2;
        checks++;
        if ({st3, en_pc3, en_f3, en_re3, en_em3, en_mw3, bub3, err3, sc3} !== {2'd0, 5'b11111, 2'b00, 4'd0}) begin
            errors++; $display("FAIL rst_mid_post got st=%0d en=%b bub=%b err=%b sc=%0d want st=0 en=11111 bub=0 err=0 sc=0",
                               st3, {en_pc3, en_f3, en_re3, en_em3, en_mw3}, bub3, err3, sc3);
        end
        @(negedge clk); #2;
        checks++;
        if ({st3, en_pc3, err3} !== 4'b0010) begin
            errors++; $display("FAIL rst_mid_next got st=%0d pc=%b err=%b want 0 1 0", st3, en_pc3, err3);
        end
    endtask

    task automatic test_random();
        int rdy_pct = 50;
        mo_t o3, o1;
        ms_t n3, n1;
        logic [25:0] e3, e1, g3, g1;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i % 200 == 0) rdy_pct = (i % 600 == 0) ? 50 : ((i % 600 == 200) ? 15 : 0);
            rst  = ($urandom_range(0, 63) == 0);
            ra   = 4'($urandom_range(0, 3)); rb = 4'($urandom_range(0, 3)); robj = 4'($urandom_range(0, 3));
            rea  = 1'($urandom_range(0, 1)); reb = 1'($urandom_range(0, 1));
            mre  = ($urandom_range(0, 2) == 0);
            mreq = ($urandom_range(0, 3) == 0);
            mrdy = ($urandom_range(0, 99) < rdy_pct);
            br   = ($urandom_range(0, 5) == 0);
            #2;
            model_step(3, 16, 15, ms3, rst, hz_now(), mreq, mrdy, br, o3, n3);
            model_step(1, 3, 65535, ms1, rst, hz_now(), mreq, mrdy, br, o1, n1);
            e3 = {o3.en_pc, o3.en_f, {3{o3.en_o}}, o3.bub, o3.fl, ms3.err, o3.st, 16'(ms3.cnt) & CMASK};
            e1 = {o1.en_pc, o1.en_f, {3{o1.en_o}}, o1.bub, o1.fl, ms1.err, o1.st, 16'(ms1.cnt) & CMASK};
            g3 = {en_pc3, en_f3, en_re3, en_em3, en_mw3, bub3, fl3, err3, st3, 12'd0, sc3};
            g1 = {en_pc1, en_f1, en_re1, en_em1, en_mw1, bub1, fl1, err1, st1, sc1};
            checks++;
            if (g3 !== e3) begin
                errors++; $display("FAIL rand3 cycle %0d got %b want %b", i, g3, e3);
            end
            checks++;
            if (g1 !== e1) begin
                errors++; $display("FAIL rand1 cycle %0d got %b want %b", i, g1, e1);
            end
        end
        @(negedge clk); rst = 1'b0; idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_use_1();
        test_load_use_3();
        test_mem_wait();
        test_timeout();
        test_branch_hz();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
